// File: rtl/rx_mac_ring_writer_if.sv
// AXI-Stream receive channel from the 10G MAC into the ring writer.
// The MAC is the master; the ring writer is the slave.
interface rx_mac_ring_writer_if;
    logic [63:0]  tdata;
    logic [7:0]   tstrb;
    logic [127:0] tuser;
    logic         tvalid;
    logic         tlast;
    logic         tready;

    modport master (output tdata, output tstrb, output tuser, output tvalid, output tlast,
                    input tready);
    modport slave  (input tdata, input tstrb, input tuser, input tvalid, input tlast,
                    output tready);
endinterface

// File: rtl/rx_mac_ring_writer.sv
// MAC Rx front end: stores each AXI-Stream frame as a record (two header words,
// then payload) in a circular buffer, and commits the record only once it is complete.
module rx_mac_ring_writer #(
    parameter int AW            = 10,
    parameter int FILL_LIMIT    = 920,
    parameter int LEN_SRC       = 0,
    parameter int TS_SRC        = 0,
    parameter int TS_INC        = 6,
    parameter int TICKS_PER_SEC = 156250000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    rx_mac_ring_writer_if.slave   s_axis,
    output logic [AW-1:0]         wr_addr,
    output logic [63:0]           wr_data,
    output logic                  wr_en,
    output logic [AW-1:0]         commited_wr_address,
    input  logic [AW-1:0]         commited_rd_address,
    output logic [31:0]           accepted_frames,
    output logic [31:0]           dropped_frames,
    output logic [31:0]           bad_frames
);
    typedef enum logic [2:0] {IDLE, DATA, HDR0, HDR1, DROP} state_t;

    localparam logic [AW-1:0] FILL_LIM = AW'(FILL_LIMIT);
    localparam logic [AW-1:0] HDR_WORDS = AW'(2);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d, cwa_q, cwa_d, wr_addr_q, wr_addr_d;
    logic [63:0]   wr_data_q, wr_data_d, ts_q, ts_d;
    logic          wr_en_q, wr_en_d, tready_q, tready_d;
    logic [31:0]   acc_q, acc_d, drop_q, drop_d, bad_q, bad_d;
    logic [7:0]    src_q, src_d, dst_q, dst_d;
    logic [15:0]   len_q, len_d, bytecnt_q, bytecnt_d;
    logic [31:0]   tick_q, tick_d, ts_sec_q, ts_sec_d, ts_nsec_q, ts_nsec_d;

    logic          beat, full;
    logic [AW-1:0] fill;
    logic [15:0]   beat_bytes, hdr_len;
    logic          unused_tuser;

    assign unused_tuser = ^s_axis.tuser[127:97];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] popcount8(input logic [7:0] v);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {15'b0, v[i]};
        return c;
    endfunction

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cwa_d      = cwa_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        tready_d   = tready_q;
        acc_d      = acc_q;
        drop_d     = drop_q;
        bad_d      = bad_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        ts_d       = ts_q;
        bytecnt_d  = bytecnt_q;

        beat       = s_axis.tvalid & tready_q;
        fill       = ptr_q - commited_rd_address;
        full       = (fill >= FILL_LIM);
        beat_bytes = popcount8(s_axis.tstrb);
        hdr_len    = (LEN_SRC == 1) ? bytecnt_q : len_q;

        // Free-running timestamp; the seconds rollover overrides the ns increment.
        if (tick_q == 32'(TICKS_PER_SEC - 1)) begin
            tick_d    = '0;
            ts_nsec_d = '0;
            ts_sec_d  = ts_sec_q + 32'd1;
        end else begin
            tick_d    = tick_q + 32'd1;
            ts_nsec_d = ts_nsec_q + 32'(TS_INC);
            ts_sec_d  = ts_sec_q;
        end

        case (state_q)
            IDLE, DATA: begin
                if (beat) begin
                    if (state_q == IDLE) begin
                        src_d     = s_axis.tuser[23:16];
                        dst_d     = s_axis.tuser[31:24];
                        len_d     = s_axis.tuser[15:0];
                        ts_d      = (TS_SRC == 1) ? {ts_sec_q, ts_nsec_q} : s_axis.tuser[95:32];
                        bytecnt_d = beat_bytes;
                    end else begin
                        bytecnt_d = bytecnt_q + beat_bytes;
                    end
                    if (full) begin
                        if (s_axis.tlast) begin
                            drop_d  = sat_inc(drop_q);
                            ptr_d   = cwa_q + HDR_WORDS;
                            state_d = IDLE;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = s_axis.tdata;
                        ptr_d     = ptr_q + AW'(1);
                        state_d   = DATA;
                        if (s_axis.tlast) begin
                            // Bad frames roll the pointer back so the space is reused.
                            if (s_axis.tuser[96]) begin
                                ptr_d   = cwa_q + HDR_WORDS;
                                bad_d   = sat_inc(bad_q);
                                state_d = IDLE;
                            end else begin
                                tready_d = 1'b0;
                                state_d  = HDR0;
                            end
                        end
                    end
                end
            end
            HDR0: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cwa_q;
                wr_data_d = {16'b0, hdr_len, 8'b0, dst_q, 8'b0, src_q};
                state_d   = HDR1;
            end
            HDR1: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cwa_q + AW'(1);
                wr_data_d = ts_q;
                cwa_d     = ptr_q;
                ptr_d     = ptr_q + HDR_WORDS;
                acc_d     = sat_inc(acc_q);
                tready_d  = 1'b1;
                state_d   = IDLE;
            end
            DROP: begin
                if (beat && s_axis.tlast) begin
                    drop_d  = sat_inc(drop_q);
                    ptr_d   = cwa_q + HDR_WORDS;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= HDR_WORDS;
            cwa_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            tready_q  <= 1'b1;
            acc_q     <= '0;
            drop_q    <= '0;
            bad_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            ts_q      <= '0;
            bytecnt_q <= '0;
            tick_q    <= '0;
            ts_sec_q  <= '0;
            ts_nsec_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cwa_q     <= cwa_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            tready_q  <= tready_d;
            acc_q     <= acc_d;
            drop_q    <= drop_d;
            bad_q     <= bad_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            ts_q      <= ts_d;
            bytecnt_q <= bytecnt_d;
            tick_q    <= tick_d;
            ts_sec_q  <= ts_sec_d;
            ts_nsec_q <= ts_nsec_d;
        end
    end

    assign s_axis.tready       = tready_q;
    assign wr_en               = wr_en_q;
    assign wr_addr             = wr_addr_q;
    assign wr_data             = wr_data_q;
    assign commited_wr_address = cwa_q;
    assign accepted_frames     = acc_q;
    assign dropped_frames      = drop_q;
    assign bad_frames          = bad_q;
endmodule

// File: tb/tb_rx_mac_ring_writer.sv
// Directed bench for rx_mac_ring_writer: a default-parameter instance plus a
// LEN_SRC=1 instance, both fed the same stream; buffer writes are captured into models.
module tb_rx_mac_ring_writer;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rx_mac_ring_writer_if ax0();
    rx_mac_ring_writer_if ax1();

    logic [AW-1:0] rd;
    logic [AW-1:0] wr_addr0, wr_addr1, cwa0, cwa1;
    logic [63:0]   wr_data0, wr_data1;
    logic          wr_en0, wr_en1;
    logic [31:0]   acc0, drop0, bad0, acc1, drop1, bad1;

    rx_mac_ring_writer #(.AW(AW)) u_dut (
        .clk(clk), .reset_n(reset_n), .s_axis(ax0),
        .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_en(wr_en0),
        .commited_wr_address(cwa0), .commited_rd_address(rd),
        .accepted_frames(acc0), .dropped_frames(drop0), .bad_frames(bad0)
    );

    rx_mac_ring_writer #(.AW(AW), .LEN_SRC(1)) u_dut_len (
        .clk(clk), .reset_n(reset_n), .s_axis(ax1),
        .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_en(wr_en1),
        .commited_wr_address(cwa1), .commited_rd_address(rd),
        .accepted_frames(acc1), .dropped_frames(drop1), .bad_frames(bad1)
    );

    logic [63:0] mem0 [0:1023];
    logic [63:0] mem1 [0:1023];
    int wcnt0 = 0;
    int hi_writes0 = 0;

    always @(posedge clk) begin
        if (wr_en0) begin
            mem0[wr_addr0] <= wr_data0;
            wcnt0 <= wcnt0 + 1;
            if (wr_addr0 >= 10'd920) hi_writes0 <= hi_writes0 + 1;
        end
        if (wr_en1) mem1[wr_addr1] <= wr_data1;
    end

    int errors = 0;
    int checks = 0;
    int stalls = 0;

    function automatic logic [127:0] mk_user(input logic [15:0] len, input logic [7:0] src,
                                             input logic [7:0] dst, input logic [63:0] ts,
                                             input logic bad);
        return {31'b0, bad, ts, dst, src, len};
    endfunction

    function automatic logic [63:0] hdr(input logic [15:0] len, input logic [7:0] dst,
                                        input logic [7:0] src);
        return {16'h0, len, 8'h0, dst, 8'h0, src};
    endfunction

    task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] s,
                         input logic [127:0] u, input logic l);
        ax0.tvalid = v; ax0.tdata = d; ax0.tstrb = s; ax0.tuser = u; ax0.tlast = l;
        ax1.tvalid = v; ax1.tdata = d; ax1.tstrb = s; ax1.tuser = u; ax1.tlast = l;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] s,
                             input logic [127:0] u, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        drive(1'b1, d, s, u, l);
        while (ax0.tready !== 1'b1 && n < 50) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL tready_timeout: tready=%b required 1 within 50 cycles", ax0.tready);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 64'h0, 8'h0, 128'h0, 1'b0);
    endtask

    task automatic send_frame(input int k, input int nbeats, input logic [15:0] len,
                              input logic [7:0] src, input logic [7:0] dst,
                              input logic [63:0] ts, input logic bad, input logic [7:0] last_strb);
        for (int i = 0; i < nbeats; i++)
            send_beat({32'(k), 32'(i)}, (i == nbeats - 1) ? last_strb : 8'hFF,
                      mk_user(len, src, dst, ts, bad), i == nbeats - 1);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b0;
        rd = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        rd = '0;
        drive(1'b0, 64'h0, 8'h0, 128'h0, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (wr_en0 !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b required 0", wr_en0); end
        checks++; if (wr_addr0 !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0d required 0", wr_addr0); end
        checks++; if (ax0.tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b required 1", ax0.tready); end
        checks++; if (cwa0 !== '0) begin errors++; $display("FAIL reset_cwa: got %0d required 0", cwa0); end
        checks++; if ({acc0, drop0, bad0} !== 96'h0) begin errors++; $display("FAIL reset_counters: got %h required 0", {acc0, drop0, bad0}); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_frame;
        int w0;
        w0 = wcnt0;
        send_frame(1, 8, 16'd64, 8'd1, 8'd2, 64'h1122, 1'b0, 8'hFF);
        @(negedge clk);
        checks++; if (ax0.tready !== 1'b0) begin errors++; $display("FAIL t1_tready: got %b required 0", ax0.tready); end
        @(negedge clk);
        checks++; if (ax0.tready !== 1'b0) begin errors++; $display("FAIL t2_tready: got %b required 0", ax0.tready); end
        checks++; if ({wr_en0, wr_addr0, wr_data0} !== {1'b1, 10'd0, 64'h0000_0040_0002_0001})
            begin errors++; $display("FAIL t2_hdr0: got en=%b addr=%0d data=%h required en=1 addr=0 data=0000004000020001", wr_en0, wr_addr0, wr_data0); end
        checks++; if (cwa0 !== 10'd0) begin errors++; $display("FAIL t2_cwa: got %0d required 0", cwa0); end
        @(negedge clk);
        checks++; if ({wr_en0, wr_addr0, wr_data0} !== {1'b1, 10'd1, 64'h1122})
            begin errors++; $display("FAIL t3_hdr1: got en=%b addr=%0d data=%h required en=1 addr=1 data=1122", wr_en0, wr_addr0, wr_data0); end
        checks++; if (cwa0 !== 10'd10) begin errors++; $display("FAIL t3_cwa: got %0d required 10", cwa0); end
        checks++; if (ax0.tready !== 1'b1) begin errors++; $display("FAIL t3_tready: got %b required 1", ax0.tready); end
        checks++; if (acc0 !== 32'd1) begin errors++; $display("FAIL single_accepted: got %0d required 1", acc0); end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem0[2 + i] !== {32'd1, 32'(i)}) begin errors++; $display("FAIL single_payload[%0d]: got %h required %h", 2 + i, mem0[2 + i], {32'd1, 32'(i)}); end
        end
        checks++; if (wcnt0 - w0 !== 10) begin errors++; $display("FAIL single_wcount: got %0d required 10", wcnt0 - w0); end
    endtask

    task automatic test_bad_frame;
        int w0;
        w0 = wcnt0;
        send_frame(2, 3, 16'd24, 8'd9, 8'd9, 64'h99, 1'b1, 8'hFF);
        repeat (4) @(negedge clk);
        checks++; if (wcnt0 - w0 !== 3) begin errors++; $display("FAIL bad_wcount: got %0d required 3", wcnt0 - w0); end
        checks++; if (cwa0 !== 10'd10) begin errors++; $display("FAIL bad_cwa: got %0d required 10", cwa0); end
        checks++; if (bad0 !== 32'd1) begin errors++; $display("FAIL bad_count: got %0d required 1", bad0); end
        checks++; if (acc0 !== 32'd1) begin errors++; $display("FAIL bad_accepted: got %0d required 1", acc0); end
        send_frame(3, 2, 16'd16, 8'd3, 8'd4, 64'h55, 1'b0, 8'hFF);
        repeat (4) @(negedge clk);
        checks++; if (mem0[12] !== {32'd3, 32'd0}) begin errors++; $display("FAIL reuse_payload0: got %h required %h", mem0[12], {32'd3, 32'd0}); end
        checks++; if (mem0[13] !== {32'd3, 32'd1}) begin errors++; $display("FAIL reuse_payload1: got %h required %h", mem0[13], {32'd3, 32'd1}); end
        checks++; if (mem0[10] !== hdr(16'd16, 8'd4, 8'd3)) begin errors++; $display("FAIL reuse_hdr0: got %h required %h", mem0[10], hdr(16'd16, 8'd4, 8'd3)); end
        checks++; if (mem0[11] !== 64'h55) begin errors++; $display("FAIL reuse_hdr1: got %h required 55", mem0[11]); end
        checks++; if (cwa0 !== 10'd14) begin errors++; $display("FAIL reuse_cwa: got %0d required 14", cwa0); end
    endtask

    task automatic test_len_src;
        send_frame(4, 3, 16'h0099, 8'd7, 8'd8, 64'hABCD, 1'b0, 8'h0F);
        repeat (4) @(negedge clk);
        checks++; if (mem1[14][47:32] !== 16'd20) begin errors++; $display("FAIL lensrc1_len: got %0d required 20", mem1[14][47:32]); end
        checks++; if (mem0[14][47:32] !== 16'h0099) begin errors++; $display("FAIL lensrc0_len: got %h required 0099", mem0[14][47:32]); end
        checks++; if (cwa1 !== 10'd19) begin errors++; $display("FAIL lensrc1_cwa: got %0d required 19", cwa1); end
    endtask

    task automatic test_fill;
        int h0;
        do_reset();
        for (int k = 0; k < 91; k++) send_frame(k, 8, 16'd64, 8'd1, 8'd2, 64'h0, 1'b0, 8'hFF);
        repeat (4) @(negedge clk);
        checks++; if (cwa0 !== 10'd910) begin errors++; $display("FAIL fill_pre_cwa: got %0d required 910", cwa0); end
        h0 = hi_writes0;
        for (int i = 0; i < 12; i++) begin
            send_beat({32'd91, 32'(i)}, 8'hFF, mk_user(16'd96, 8'd1, 8'd2, 64'h0, 1'b0), i == 11);
            if (i == 7) stalls = 0;
        end
        checks++; if (stalls !== 0) begin errors++; $display("FAIL drop_tready_stalls: got %0d required 0", stalls); end
        repeat (4) @(negedge clk);
        checks++; if (drop0 !== 32'd1) begin errors++; $display("FAIL drop_count: got %0d required 1", drop0); end
        checks++; if (cwa0 !== 10'd910) begin errors++; $display("FAIL drop_cwa: got %0d required 910", cwa0); end
        checks++; if (hi_writes0 !== h0) begin errors++; $display("FAIL drop_overrun: got %0d writes at >=920 required 0", hi_writes0 - h0); end
        checks++; if (mem0[919] !== {32'd91, 32'd7}) begin errors++; $display("FAIL drop_last_word: got %h required %h", mem0[919], {32'd91, 32'd7}); end
        send_frame(200, 2, 16'd16, 8'd1, 8'd2, 64'h0, 1'b0, 8'hFF);
        repeat (4) @(negedge clk);
        checks++; if (mem0[912] !== {32'd200, 32'd0}) begin errors++; $display("FAIL after_drop_payload: got %h required %h", mem0[912], {32'd200, 32'd0}); end
        checks++; if (cwa0 !== 10'd914) begin errors++; $display("FAIL after_drop_cwa: got %0d required 914", cwa0); end
        checks++; if (acc0 !== 32'd92) begin errors++; $display("FAIL after_drop_accepted: got %0d required 92", acc0); end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] base, nxt;
        do_reset();
        for (int k = 0; k < 200; k++) begin
            rd = cwa0;
            send_frame(k, 8, 16'd64, 8'(k), 8'd5, 64'(k), 1'b0, 8'hFF);
            repeat (3) @(negedge clk);
            base = AW'((10 * k) % 1024);
            nxt  = AW'((10 * (k + 1)) % 1024);
            checks++; if (mem0[base] !== hdr(16'd64, 8'd5, 8'(k))) begin errors++; $display("FAIL wrap_hdr0 frame %0d: got %h required %h", k, mem0[base], hdr(16'd64, 8'd5, 8'(k))); end
            checks++; if (cwa0 !== nxt) begin errors++; $display("FAIL wrap_cwa frame %0d: got %0d required %0d", k, cwa0, nxt); end
        end
        checks++; if (mem0[0] !== {32'd102, 32'd2}) begin errors++; $display("FAIL wrap_payload_at_0: got %h required %h", mem0[0], {32'd102, 32'd2}); end
        checks++; if (mem0[1023] !== {32'd102, 32'd1}) begin errors++; $display("FAIL wrap_payload_at_1023: got %h required %h", mem0[1023], {32'd102, 32'd1}); end
        checks++; if (acc0 !== 32'd200) begin errors++; $display("FAIL wrap_accepted: got %0d required 200", acc0); end
    endtask

    task automatic test_reset_midframe;
        int w0;
        rd = cwa0;
        for (int i = 0; i < 3; i++)
            send_beat({32'd50, 32'(i)}, 8'hFF, mk_user(16'd64, 8'd1, 8'd1, 64'h0, 1'b0), 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        rd = '0;
        #1;
        checks++; if ({wr_en0, wr_addr0, wr_data0} !== 75'h0) begin errors++; $display("FAIL midrst_wr: got en=%b addr=%0d data=%h required all 0", wr_en0, wr_addr0, wr_data0); end
        checks++; if (cwa0 !== '0) begin errors++; $display("FAIL midrst_cwa: got %0d required 0", cwa0); end
        checks++; if (ax0.tready !== 1'b1) begin errors++; $display("FAIL midrst_tready: got %b required 1", ax0.tready); end
        checks++; if (acc0 !== 32'd0) begin errors++; $display("FAIL midrst_accepted: got %0d required 0", acc0); end
        @(negedge clk);
        reset_n = 1'b1;
        w0 = wcnt0;
        send_frame(7, 1, 16'd8, 8'd3, 8'd6, 64'h77, 1'b0, 8'hFF);
        repeat (4) @(negedge clk);
        checks++; if (mem0[2] !== {32'd7, 32'd0}) begin errors++; $display("FAIL postrst_payload: got %h required %h", mem0[2], {32'd7, 32'd0}); end
        checks++; if (mem0[0] !== hdr(16'd8, 8'd6, 8'd3)) begin errors++; $display("FAIL postrst_hdr0: got %h required %h", mem0[0], hdr(16'd8, 8'd6, 8'd3)); end
        checks++; if (mem0[1] !== 64'h77) begin errors++; $display("FAIL postrst_hdr1: got %h required 77", mem0[1]); end
        checks++; if (cwa0 !== 10'd3) begin errors++; $display("FAIL postrst_cwa: got %0d required 3", cwa0); end
        checks++; if (wcnt0 - w0 !== 3) begin errors++; $display("FAIL postrst_wcount: got %0d required 3", wcnt0 - w0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bad_frame();
        test_len_src();
        test_fill();
        test_wrap();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rx_mac_ring_writer.md
Name: rx_mac_ring_writer

Overview:
- Parametrised next-generation MAC Rx front end.
- Accepts AXI-Stream frames from the 10G MAC and writes each frame as a record into a circular 64-bit buffer of 2**AW words.
- Record layout: 2 header words (length/ports, timestamp) followed by payload words. A record is committed to the DMA side only after it is completely written.
- Adds over the previous generation: configurable depth and fill limit, bad-FCS discard, a choice of length and timestamp source, real write-enable gating, and accepted/dropped/bad counters.

Parameters:
- AW, 10, buffer address width in words (depth = 2**AW).
- FILL_LIMIT, 920, overflow threshold in words; must be < 2**AW - 2.
- LEN_SRC, 0, 0 = header length taken from s_axis_tuser[15:0]; 1 = length counted from tstrb popcount.
- TS_SRC, 0, 0 = timestamp taken from s_axis_tuser[95:32]; 1 = internal {ts_sec, ts_nsec}.
- TS_INC, 6, ns added to ts_nsec per clock.
- TICKS_PER_SEC, 156250000, clocks per second.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  64  Rx payload
- s_axis_tstrb  in  8  byte valid, contiguous from bit 0
- s_axis_tuser  in  128  [15:0] len, [23:16] src port, [31:24] dst port, [95:32] timestamp, [96] bad frame (valid on tlast beat)
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat
- s_axis_tready  out  1  beat accept
- wr_addr  out  AW  buffer write address
- wr_data  out  64  buffer write data
- wr_en  out  1  buffer write strobe
- commited_wr_address  out  AW  base of next free record; all records below it are complete
- commited_rd_address  in  AW  consumer's committed read pointer
- accepted_frames  out  32  committed frame count
- dropped_frames  out  32  frames dropped for overflow
- bad_frames  out  32  frames discarded for tuser[96]

Behaviour:
- Reset values (async on reset_n low): commited_wr_address=0; write pointer ptr=2; wr_en=0; wr_addr=0; wr_data=0; s_axis_tready=1; all counters 0; ts_sec=ts_nsec=tick=0; state IDLE.
- Reset mid-frame: the partial frame is lost and nothing is committed.
- Beat accepted = s_axis_tvalid & s_axis_tready. No other input is sampled as data.
- Address arithmetic: all address math is modulo 2**AW and wraps silently.
- Fill: fill = (ptr - commited_rd_address) mod 2**AW, evaluated combinationally at each accepted beat.
- Buffer write: every write is registered. wr_en=1 for exactly one cycle per write, in the cycle after the decision; wr_en=0 otherwise.
- States:
  - IDLE: tready=1. On an accepted beat:
    - Latch src, dst, tuser len and timestamp (per TS_SRC). Set bytecnt = popcount(tstrb).
    - If fill >= FILL_LIMIT, do not write the beat. If tlast: dropped_frames++ and stay IDLE; else go to DROP.
    - Otherwise write tdata at ptr and increment ptr. If tlast, go to CHECK handling (below); else go to DATA.
  - DATA: on each accepted beat:
    - If fill >= FILL_LIMIT, do not write the beat. If tlast: dropped_frames++, ptr=commited_wr_address+2, go IDLE; else go to DROP.
    - Otherwise write the beat, ptr++, bytecnt += popcount(tstrb).
    - On tlast: if tuser[96]=1, set ptr=commited_wr_address+2, bad_frames++, go IDLE (no header written, no commit). Else deassert tready (registered) and go to HDR0.
  - HDR0: write {16'b0, len, 8'b0, dst, 8'b0, src} at commited_wr_address. len is the latched tuser length (LEN_SRC=0) or bytecnt (LEN_SRC=1). Go to HDR1.
  - HDR1: write the timestamp at commited_wr_address+1. Set commited_wr_address <= ptr, ptr <= ptr+2, accepted_frames++, tready <= 1. Go IDLE.
  - DROP: tready=1. Discard beats. On an accepted tlast: dropped_frames++, ptr=commited_wr_address+2, go IDLE.
- Latency: tlast accepted at cycle T. Header0 write strobe at T+2, header1 strobe at T+3, new commited_wr_address visible at T+3. tready is low during T+1..T+2.
- The tlast check in IDLE (single-beat frame) applies the same tuser[96] test as DATA.
- Counters saturate at 32'hFFFFFFFF.
- Timestamp generator:
  - Each cycle: tick++, ts_nsec += TS_INC.
  - When tick == TICKS_PER_SEC-1: tick=0, ts_nsec=0, ts_sec++ (this takes priority over the increment).
- Invariant: a write never targets an address in [commited_rd_address, commited_wr_address) unread space. FILL_LIMIT below 2**AW-2 guarantees header space.

Test Plan:
- Single 8-beat frame, tuser len=64, src=1, dst=2, ts=0x1122, AW=10 -> payload written at addresses 2..9; header0 = 0x0000_0040_0002_0001 at addr 0; header1 = 0x1122 at addr 1; commited_wr_address=10 at T+3; accepted_frames=1.
- Frame with tuser[96]=1 on tlast -> no header writes; commited_wr_address unchanged; bad_frames=1; next frame payload starts at commited+2.
- commited_rd_address held at 0, FILL_LIMIT=920, frames streamed until fill reached -> frame in progress dropped; tready stays 1 in DROP; dropped_frames++; commited_wr_address unchanged; no write beyond address 919.
- Wrap: set commited_rd_address to follow commited_wr_address, stream 200 64-byte frames -> addresses wrap 1023->0 and each header is at the correct wrapped base.
- LEN_SRC=1, last beat tstrb=8'h0F on a 3-beat frame -> header length field = 20.
- reset_n pulsed low mid-frame -> all outputs return to reset values immediately; the first frame after reset writes payload from addr 2.
